// File: rtl/tank_access_sequencer_pkg.sv
// Shared store constants, FSM state and port ids for the
// mercury-delay-line access sequencer and its timing logic.
package edsac_store_pkg;

  localparam int DIGITS_PER_MINOR = 18;
  localparam int SLOT_BITS        = 5;
  localparam int TANK_BITS        = 5;
  localparam int DIGIT_BITS       = 5;

  localparam logic [DIGIT_BITS-1:0] DIGIT_LAST =
    DIGIT_BITS'(DIGITS_PER_MINOR - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SLOT,
    XFER,
    DONE
  } state_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  typedef struct packed {
    logic                 wr;
    logic [TANK_BITS-1:0] tank;
    logic [SLOT_BITS-1:0] slot;
  } store_req_t;

  // Slot that sits at the tank head one minor cycle before s.
  function automatic logic [SLOT_BITS-1:0] prev_slot(
    input logic [SLOT_BITS-1:0] s
  );
    return s - SLOT_BITS'(1);
  endfunction

endpackage

// File: rtl/tank_access_sequencer_if.sv
// Request/ack bundle for the two store requesters
// (A = order fetch, B = operand access).
interface tank_access_sequencer_if;
  import edsac_store_pkg::*;

  logic                 req_a;
  logic                 wr_a;
  logic [TANK_BITS-1:0] tank_a;
  logic [SLOT_BITS-1:0] slot_a;
  logic                 ack_a;

  logic                 req_b;
  logic                 wr_b;
  logic [TANK_BITS-1:0] tank_b;
  logic [SLOT_BITS-1:0] slot_b;
  logic                 ack_b;

  modport master (
    output req_a, wr_a, tank_a, slot_a,
    output req_b, wr_b, tank_b, slot_b,
    input  ack_a, ack_b
  );

  modport slave (
    input  req_a, wr_a, tank_a, slot_a,
    input  req_b, wr_b, tank_b, slot_b,
    output ack_a, ack_b
  );

endinterface

// File: rtl/tank_access_sequencer_timing.sv
// Free-running digit / minor-cycle counters for the store;
// also reused by the tank regeneration logic.
module store_timing_counter
  import edsac_store_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  output logic [DIGIT_BITS-1:0] digit_cnt_o,
  output logic [SLOT_BITS-1:0]  slot_cnt_o,
  output logic                  minor_sync_o
);

  logic [DIGIT_BITS-1:0] digit_q, digit_d;
  logic [SLOT_BITS-1:0]  slot_q, slot_d;
  logic                  wrap;

  always_comb begin
    wrap    = (digit_q == DIGIT_LAST);
    digit_d = wrap ? '0 : digit_q + DIGIT_BITS'(1);
    slot_d  = wrap ? slot_q + SLOT_BITS'(1) : slot_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q <= '0;
      slot_q  <= '0;
    end else begin
      digit_q <= digit_d;
      slot_q  <= slot_d;
    end
  end

  assign digit_cnt_o  = digit_q;
  assign slot_cnt_o   = slot_q;
  assign minor_sync_o = (digit_q == '0);

endmodule

// File: rtl/tank_access_sequencer.sv
// Arbitrates two store requesters, drives dual-rail tank lines and
// opens the tank read/write path for the addressed minor cycle.
module tank_access_sequencer
  import edsac_store_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  tank_access_sequencer_if.slave bus,
  output logic [TANK_BITS-1:0]  f_pos,
  output logic [TANK_BITS-1:0]  f_neg,
  output logic                  t_in,
  output logic                  t_out,
  output logic [DIGIT_BITS-1:0] digit_cnt,
  output logic [SLOT_BITS-1:0]  slot_cnt,
  output logic                  minor_sync
);

  state_e               state_q, state_d;
  port_e                last_q, last_d;
  port_e                cur_q, cur_d;
  store_req_t           lat_q, lat_d;
  logic [TANK_BITS-1:0] f_q, f_d;
  logic                 t_in_q, t_in_d;
  logic                 t_out_q, t_out_d;
  logic                 ack_a_q, ack_a_d;
  logic                 ack_b_q, ack_b_d;

  logic                 gnt_vld;
  port_e                gnt;
  store_req_t           req_a_s, req_b_s;
  logic                 minor_end;

  store_timing_counter u_timing (
    .clk          (clk),
    .rst          (rst),
    .digit_cnt_o  (digit_cnt),
    .slot_cnt_o   (slot_cnt),
    .minor_sync_o (minor_sync)
  );

  assign req_a_s   = '{wr: bus.wr_a, tank: bus.tank_a, slot: bus.slot_a};
  assign req_b_s   = '{wr: bus.wr_b, tank: bus.tank_b, slot: bus.slot_b};
  assign minor_end = (digit_cnt == DIGIT_LAST);

  // Round robin: on a conflict the port not granted last time wins.
  always_comb begin
    gnt_vld = 1'b1;
    gnt     = PORT_A;
    unique case (1'b1)
      bus.req_a & ~bus.req_b: gnt = PORT_A;
      ~bus.req_a & bus.req_b: gnt = PORT_B;
      bus.req_a & bus.req_b:
        gnt = (last_q == PORT_A) ? PORT_B : PORT_A;
      default: gnt_vld = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cur_d   = cur_q;
    lat_d   = lat_q;
    f_d     = f_q;
    t_in_d  = 1'b0;
    t_out_d = 1'b0;
    ack_a_d = 1'b0;
    ack_b_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        f_d = '0;
        if (gnt_vld) begin
          cur_d   = gnt;
          last_d  = gnt;
          lat_d   = (gnt == PORT_B) ? req_b_s : req_a_s;
          f_d     = lat_d.tank;
          state_d = WAIT_SLOT;
        end
      end
      WAIT_SLOT: begin
        if (minor_end && slot_cnt == prev_slot(lat_q.slot)) begin
          t_in_d  = lat_q.wr;
          t_out_d = ~lat_q.wr;
          state_d = XFER;
        end
      end
      XFER: begin
        if (minor_end) begin
          ack_a_d = (cur_q == PORT_A);
          ack_b_d = (cur_q == PORT_B);
          state_d = DONE;
        end else begin
          t_in_d  = lat_q.wr;
          t_out_d = ~lat_q.wr;
        end
      end
      DONE: begin
        f_d     = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= PORT_A;
      cur_q   <= PORT_A;
      lat_q   <= '0;
      f_q     <= '0;
      t_in_q  <= 1'b0;
      t_out_q <= 1'b0;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cur_q   <= cur_d;
      lat_q   <= lat_d;
      f_q     <= f_d;
      t_in_q  <= t_in_d;
      t_out_q <= t_out_d;
      ack_a_q <= ack_a_d;
      ack_b_q <= ack_b_d;
    end
  end

  assign f_pos     = f_q;
  assign f_neg     = ~f_q;
  assign t_in      = t_in_q;
  assign t_out     = t_out_q;
  assign bus.ack_a = ack_a_q;
  assign bus.ack_b = ack_b_q;

endmodule

// File: tb/tb_tank_access_sequencer.sv
// Directed bench for tank_access_sequencer with a cycle-count model
// of the store timing counters.
module tb_tank_access_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] f_pos, f_neg;
  logic       t_in, t_out;
  logic [4:0] digit_cnt;
  logic [4:0] slot_cnt;
  logic       minor_sync;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  tank_access_sequencer_if bus ();

  tank_access_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .f_pos      (f_pos),
    .f_neg      (f_neg),
    .t_in       (t_in),
    .t_out      (t_out),
    .digit_cnt  (digit_cnt),
    .slot_cnt   (slot_cnt),
    .minor_sync (minor_sync)
  );

  always #5 clk = ~clk;

  function automatic int md();
    return cyc % 18;
  endfunction

  function automatic int ms();
    return (cyc / 18) % 32;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    chk("t_excl", {31'b0, t_in & t_out}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic goto(int d, int s);
    int n = 0;
    while ((md() != d || ms() != s) && n < 1200) begin
      tick();
      n++;
    end
    chk("goto_digit", 32'(digit_cnt), 32'(d));
    chk("goto_slot", 32'(slot_cnt), 32'(s));
  endtask

  task automatic wait_t(output int n);
    n = 0;
    while (!(t_in | t_out) && n < 1200) begin
      tick();
      n++;
    end
    chk("wait_t_timeout", 32'(n < 1200), 32'd1);
  endtask

  task automatic wait_ack(output logic a, output logic b);
    int n = 0;
    while (!(bus.ack_a | bus.ack_b) && n < 1300) begin
      tick();
      n++;
    end
    chk("wait_ack_timeout", 32'(n < 1300), 32'd1);
    a = bus.ack_a;
    b = bus.ack_b;
  endtask

  task automatic xfer18(output int nin, output int nout, output int nack);
    nin = 0;
    nout = 0;
    nack = 0;
    for (int i = 0; i < 18; i++) begin
      nin  += int'(t_in);
      nout += int'(t_out);
      nack += int'(bus.ack_a | bus.ack_b);
      tick();
    end
  endtask

  initial begin
    int   n, nin, nout, nack;
    logic a, b;

    rst = 1'b1;
    bus.req_a = 0; bus.wr_a = 0; bus.tank_a = 0; bus.slot_a = 0;
    bus.req_b = 0; bus.wr_b = 0; bus.tank_b = 0; bus.slot_b = 0;
    do_reset();

    // 1. reset state
    chk("rst_fpos", 32'(f_pos), 32'h00);
    chk("rst_fneg", 32'(f_neg), 32'h1f);
    chk("rst_tin", 32'(t_in), 32'd0);
    chk("rst_tout", 32'(t_out), 32'd0);
    chk("rst_acka", 32'(bus.ack_a), 32'd0);
    chk("rst_ackb", 32'(bus.ack_b), 32'd0);
    chk("rst_digit", 32'(digit_cnt), 32'd0);
    chk("rst_slot", 32'(slot_cnt), 32'd0);
    chk("rst_sync", 32'(minor_sync), 32'd1);

    // 2. read tank 5 slot 3 from (0,0)
    bus.req_a = 1; bus.wr_a = 0; bus.tank_a = 5; bus.slot_a = 3;
    tick();
    chk("rd_fpos", 32'(f_pos), 32'h05);
    chk("rd_fneg", 32'(f_neg), 32'h1a);
    chk("rd_sync_low", 32'(minor_sync), 32'd0);
    goto(17, 2);
    chk("rd_tout_pre", 32'(t_out), 32'd0);
    tick();
    chk("rd_tout_start", 32'(t_out), 32'd1);
    chk("rd_start_digit", 32'(digit_cnt), 32'd0);
    chk("rd_start_slot", 32'(slot_cnt), 32'd3);
    xfer18(nin, nout, nack);
    chk("rd_tout_cnt", 32'(nout), 32'd18);
    chk("rd_tin_cnt", 32'(nin), 32'd0);
    chk("rd_early_ack", 32'(nack), 32'd0);
    chk("rd_acka", 32'(bus.ack_a), 32'd1);
    chk("rd_ackb", 32'(bus.ack_b), 32'd0);
    chk("rd_done_tout", 32'(t_out), 32'd0);
    chk("rd_done_fpos", 32'(f_pos), 32'h05);
    chk("rd_done_slot", 32'(slot_cnt), 32'd4);
    bus.req_a = 0;
    tick();
    chk("rd_ack_once", 32'(bus.ack_a), 32'd0);
    chk("rd_idle_fpos", 32'(f_pos), 32'h00);
    chk("rd_idle_fneg", 32'(f_neg), 32'h1f);

    // 3. wrap-around: slot 0 granted at digit 5 of slot 0
    goto(5, 0);
    bus.req_b = 1; bus.wr_b = 0; bus.tank_b = 9; bus.slot_b = 0;
    n = 0;
    while (!t_out && n < 700) begin
      tick();
      n++;
    end
    chk("wrap_latency", 32'(n), 32'd571);
    chk("wrap_digit", 32'(digit_cnt), 32'd0);
    chk("wrap_slot", 32'(slot_cnt), 32'(ms()));
    chk("wrap_fpos", 32'(f_pos), 32'h09);
    xfer18(nin, nout, nack);
    chk("wrap_tout_cnt", 32'(nout), 32'd18);
    chk("wrap_ackb", 32'(bus.ack_b), 32'd1);
    bus.req_b = 0;
    tick();

    // 4. conflicts alternate, B first after reset
    do_reset();
    bus.req_a = 1; bus.wr_a = 0; bus.tank_a = 1; bus.slot_a = 2;
    bus.req_b = 1; bus.wr_b = 1; bus.tank_b = 2; bus.slot_b = 4;
    tick();
    chk("cf1_fpos_b", 32'(f_pos), 32'h02);
    wait_ack(a, b);
    chk("cf1_ack_b", {30'b0, a, b}, 32'b01);
    bus.req_b = 0;
    tick();
    tick();
    chk("cf1_fpos_a", 32'(f_pos), 32'h01);
    wait_ack(a, b);
    chk("cf1_ack_a", {30'b0, a, b}, 32'b10);
    bus.req_b = 1;
    tick();
    tick();
    chk("cf2_fpos_b", 32'(f_pos), 32'h02);
    wait_ack(a, b);
    chk("cf2_ack_b", {30'b0, a, b}, 32'b01);
    bus.req_b = 0;
    tick();
    tick();
    chk("cf2_fpos_a", 32'(f_pos), 32'h01);
    wait_ack(a, b);
    chk("cf2_ack_a", {30'b0, a, b}, 32'b10);
    bus.req_a = 0;
    tick();

    // 5. write tank 31 slot 31
    bus.req_b = 1; bus.wr_b = 1; bus.tank_b = 31; bus.slot_b = 31;
    wait_t(n);
    chk("wr_tin", 32'(t_in), 32'd1);
    chk("wr_digit", 32'(digit_cnt), 32'd0);
    chk("wr_slot", 32'(slot_cnt), 32'd31);
    chk("wr_model_slot", 32'(ms()), 32'd31);
    chk("wr_fneg", 32'(f_neg), 32'h00);
    xfer18(nin, nout, nack);
    chk("wr_tin_cnt", 32'(nin), 32'd18);
    chk("wr_tout_cnt", 32'(nout), 32'd0);
    chk("wr_ackb", 32'(bus.ack_b), 32'd1);
    chk("wr_ack_digit", 32'(digit_cnt), 32'd0);
    chk("wr_ack_slot", 32'(slot_cnt), 32'd0);
    bus.req_b = 0;
    tick();

    // 6. reset in the middle of a transfer
    bus.req_a = 1; bus.wr_a = 0; bus.tank_a = 7; bus.slot_a = 10;
    wait_t(n);
    chk("mid_tout", 32'(t_out), 32'd1);
    for (int i = 0; i < 7; i++) tick();
    chk("mid_digit7", 32'(digit_cnt), 32'd7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    bus.req_a = 0;
    chk("mid_tout_drop", 32'(t_out), 32'd0);
    chk("mid_tin_drop", 32'(t_in), 32'd0);
    chk("mid_no_ack", {30'b0, bus.ack_a, bus.ack_b}, 32'd0);
    chk("mid_digit", 32'(digit_cnt), 32'd0);
    chk("mid_slot", 32'(slot_cnt), 32'd0);
    chk("mid_fpos", 32'(f_pos), 32'h00);
    nack = 0;
    for (int i = 0; i < 40; i++) begin
      nack += int'(bus.ack_a | bus.ack_b | t_in | t_out);
      tick();
    end
    chk("mid_quiet", 32'(nack), 32'd0);
    bus.req_b = 1; bus.wr_b = 1; bus.tank_b = 3; bus.slot_b = 5;
    wait_t(n);
    chk("post_tin", 32'(t_in), 32'd1);
    chk("post_slot", 32'(slot_cnt), 32'(ms()));
    chk("post_slot5", 32'(slot_cnt), 32'd5);
    chk("post_digit", 32'(digit_cnt), 32'(md()));
    xfer18(nin, nout, nack);
    chk("post_tin_cnt", 32'(nin), 32'd18);
    chk("post_ackb", 32'(bus.ack_b), 32'd1);
    bus.req_b = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tank_access_sequencer.md
Name: tank_access_sequencer

Overview:
- Schedules accesses to the mercury-delay-line store. Two requesters share it: order fetch on port A and operand access on port B.
- For the granted request it drives the dual-rail tank-number lines (f_pos/f_neg) into the tank distribution and decoder chain.
- It then waits until the addressed word circulates past the tank head and asserts the read-path enable (t_out) or the write-path enable (t_in) for exactly one minor cycle.
- It owns the store's digit and minor-cycle timing counters and sits between main control and the tank decoder tree.

Parameters:
- DIGITS_PER_MINOR, 18, digit periods (clk cycles) per minor cycle (one short word).
- SLOT_BITS, 5, log2 of minor cycles per major cycle; 32 word slots per tank.
- TANK_BITS, 5, width of the tank-number field; 32 tanks.

Ports:
- clk  in  1  digit clock; one cycle = one digit period.
- rst  in  1  synchronous, active-high reset.
- req_a  in  1  port A (order fetch) request; held until ack_a.
- wr_a  in  1  port A direction: 1 = write, 0 = read.
- tank_a  in  TANK_BITS  port A tank number.
- slot_a  in  SLOT_BITS  port A word slot within the tank.
- ack_a  out  1  one-cycle completion pulse to port A.
- req_b, wr_b, tank_b, slot_b, ack_b  same as port A, for port B (operand).
- f_pos  out  TANK_BITS  tank address, true rail.
- f_neg  out  TANK_BITS  tank address, complement rail; always equal to ~f_pos.
- t_in  out  1  write-path enable into the selected tank.
- t_out  out  1  read-path enable from the selected tank.
- digit_cnt  out  5  current digit position, 0..DIGITS_PER_MINOR-1.
- slot_cnt  out  SLOT_BITS  current minor cycle, i.e. the slot at the tank head.
- minor_sync  out  1  high when digit_cnt==0.

Behaviour:
- Reset values:
  - digit_cnt=0, slot_cnt=0, minor_sync=1.
  - f_pos=0, f_neg=all ones.
  - t_in=0, t_out=0, ack_a=0, ack_b=0.
  - state=IDLE, last_grant=A.
- Reset asserted mid-operation aborts the transfer: t_in/t_out drop on the next edge and no ack is issued.
- Timing counters:
  - digit_cnt increments every cycle and wraps DIGITS_PER_MINOR-1 -> 0.
  - slot_cnt increments when digit_cnt wraps, modulo 2^SLOT_BITS.
  - The counters free-run and are independent of the FSM.
- FSM states: IDLE, WAIT_SLOT, XFER, DONE.
- IDLE:
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, grant that port.
  - If both are high, grant the port that is not last_grant (round robin). Since last_grant resets to A, B wins the first conflict.
  - On grant: latch tank, slot and wr; set last_grant; register f_pos=tank and f_neg=~tank; go to WAIT_SLOT.
- WAIT_SLOT:
  - Go to XFER when digit_cnt==DIGITS_PER_MINOR-1 and slot_cnt==(target-1) mod 2^SLOT_BITS.
  - XFER therefore starts at digit_cnt==0, slot_cnt==target.
  - If that boundary falls in the grant cycle itself, it is missed and the sequencer waits a full major cycle. This is deterministic and required.
- XFER:
  - t_out=~wr, t_in=wr, both registered, high for exactly DIGITS_PER_MINOR cycles.
  - On the cycle where digit_cnt==DIGITS_PER_MINOR-1, go to DONE.
- DONE:
  - t_in/t_out=0; ack of the granted port=1 for this single cycle.
  - f lines stay held through DONE.
  - Next state is IDLE; f_pos returns to 0 and f_neg to all ones.
- Handshake:
  - req, tank, slot and wr must be stable from assertion until ack.
  - The requester must drop req in the cycle after ack unless it is issuing a new request.
  - A new request is evaluated in IDLE, at the earliest the cycle after DONE.
- Latency from grant to XFER start: between 1 and 32*18 cycles. ack follows 18 cycles after XFER start.
- Invariants: t_in and t_out are never high together; at most one ack per access.

Decomposition:
- Shared package edsac_store_pkg holds:
  - DIGITS_PER_MINOR, SLOT_BITS, TANK_BITS;
  - the state enum {IDLE, WAIT_SLOT, XFER, DONE};
  - the port-id constants PORT_A and PORT_B.
- One sub-module, store_timing_counter, provides digit_cnt, slot_cnt and minor_sync. It is reusable by the tank regeneration logic.
- The arbiter and FSM stay in the top module.

Test Plan:
1. Reset check: after rst, expect f_pos=00000, f_neg=11111, t_in=t_out=0, digit_cnt=0, slot_cnt=0, minor_sync=1.
2. Read, tank 5 slot 3:
   - Stimulus: req_a with wr_a=0, tank_a=5, slot_a=3, raised at counters (0,0).
   - Expect f_pos=00101 and f_neg=11010 from the next cycle.
   - Expect t_out high for 18 cycles starting at (0,3); t_in stays 0.
   - Expect a single ack_a at (0,4).
3. Wrap-around:
   - Stimulus: req_b read with slot_b=0, granted at digit 5 of slot 0.
   - Expect t_out to start at (0,0) of the next major cycle, 571 cycles after the grant.
4. Conflict:
   - Stimulus: req_a and req_b high in the same cycle after reset.
   - Expect B served first, then A. Stimulus: a second simultaneous conflict after that.
   - Expect A not served back-to-back twice; grants alternate.
5. Write, tank 31 slot 31:
   - Expect t_in high for 18 cycles at (0,31) and t_out stays 0.
   - Expect ack_b at (0,0).
6. Reset mid-XFER:
   - Stimulus: assert rst at digit 7 of the transfer.
   - Expect t_in/t_out=0 on the next cycle, no ack, counters at 0, state IDLE.
   - Expect a fresh request afterwards to complete normally.
